step_profile_gen: RTL and testbench

- Trapezoidal-profile step/direction generator for one stepper axis. Successor to the single-shot angle-to-step block.
- Takes a signed relative step count. Runs linear accel, cruise and decel phases with integer clock-count periods.
- Adds direction output, a direction setup delay, controlled stop, step/done status and parametrised widths.
- Sits between the motion command layer and the driver's STEP/DIR pins.

---
 rtl/step_profile_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_step_profile_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_profile_gen.sv
// -----------------------------------------------------------------------------
// step_profile_gen
//   Trapezoidal-profile STEP/DIR generator for one stepper axis. A signed
//   relative step count is latched on start. The block drives DIR, waits a
//   direction setup time, then emits steps whose period ramps linearly from
//   START_PERIOD down to MIN_PERIOD (accel), holds (cruise) and ramps back up
//   (decel) so the last step is again at START_PERIOD. A controlled stop
//   shortens the move to the steps needed to ramp back down.
//
// Optional feature (macro STEP_PROFILE_POSITION_EN):
//   adds pos_o, a signed absolute position updated on every step_o rise.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   start_i       level; starts a move when idle (ignored while busy)
//   stop_i        level; controlled stop request
//   steps_i       signed relative step count, latched on start
//   busy_o        move in progress
//   done_o        idle (inverse of busy_o)
//   dir_o         1 = negative direction
//   step_o        step pulse, PULSE_W clocks high per interval
//   steps_done_o  steps completed in the current or last move
//   pos_o         absolute position (STEP_PROFILE_POSITION_EN only)
// -----------------------------------------------------------------------------
module step_profile_gen #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PER_W        = 24,
  parameter int unsigned START_PERIOD = 25000,
  parameter int unsigned MIN_PERIOD   = 2500,
  parameter int unsigned ACCEL_DEC    = 100,
  parameter int unsigned PULSE_W      = 50,
  parameter int unsigned DIR_SETUP    = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic signed [CNT_W-1:0] steps_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    dir_o,
  output logic                    step_o,
  output logic        [CNT_W-1:0] steps_done_o
`ifdef STEP_PROFILE_POSITION_EN
  ,
  output logic signed [CNT_W-1:0] pos_o
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCEL, CRUISE, DECEL} state_e;

  // Period arithmetic is done one bit wider so +ACCEL_DEC cannot wrap
  // before it is clamped back to START_PERIOD.
  localparam logic [PER_W:0]   START_X = (PER_W+1)'(START_PERIOD);
  localparam logic [PER_W:0]   MIN_X   = (PER_W+1)'(MIN_PERIOD);
  localparam logic [PER_W:0]   ACC_X   = (PER_W+1)'(ACCEL_DEC);
  localparam logic [PER_W-1:0] PW_P    = PER_W'(PULSE_W);
  localparam logic [PER_W-1:0] DS_LAST = PER_W'(DIR_SETUP - 1);

  state_e           state_q, state_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             stop_pend_q, stop_pend_d;

  logic [CNT_W-1:0] steps_u;
  logic [CNT_W-1:0] mag;
  logic [CNT_W-1:0] done_inc;
  logic [CNT_W-1:0] ramp_dec;
  logic [CNT_W:0]   stop_sum;
  logic [CNT_W-1:0] tgt_eff;
  logic [CNT_W-1:0] rem;
  logic [PER_W:0]   per_ext;
  logic [PER_W:0]   per_up;
  logic [PER_W:0]   per_dn;
  logic             iv_end;
  logic             stop_req;

  // NOTE: every signal written below gets its default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    ramp_d      = ramp_q;
    target_d    = target_q;
    done_d      = done_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    stop_pend_d = stop_pend_q;

    // Magnitude of a two's-complement count; -2^(CNT_W-1) maps to 2^(CNT_W-1).
    steps_u  = steps_i;
    mag      = steps_u[CNT_W-1] ? (~steps_u + CNT_W'(1)) : steps_u;

    done_inc = done_q + CNT_W'(1);
    ramp_dec = (ramp_q == '0) ? '0 : ramp_q - CNT_W'(1);

    per_ext  = {1'b0, period_q};
    per_up   = per_ext + ACC_X;
    if (per_up > START_X) per_up = START_X;
    per_dn   = (per_ext >= MIN_X + ACC_X) ? per_ext - ACC_X : MIN_X;

    iv_end   = (cnt_q == period_q - PER_W'(1));
    stop_req = (stop_pend_q | stop_i) && (state_q == ACCEL || state_q == CRUISE);

    // A stop only ever shortens a move: the ramp-down target is clamped to
    // the commanded target, so a stop at the final step has no effect.
    stop_sum = {1'b0, done_inc} + {1'b0, ramp_q};
    tgt_eff  = (stop_req && stop_sum < {1'b0, target_q}) ? stop_sum[CNT_W-1:0] : target_q;
    rem      = tgt_eff - done_inc;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          done_d      = '0;
          period_d    = START_X[PER_W-1:0];
          ramp_d      = '0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          if (mag != '0) begin
            target_d = mag;
            dir_d    = steps_u[CNT_W-1];
            busy_d   = 1'b1;
            state_d  = (DIR_SETUP == 0) ? ACCEL : SETUP;
          end
        end
      end

      SETUP: begin
        if (stop_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == DS_LAST) begin
          state_d = ACCEL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PER_W'(1);
        end
      end

      ACCEL, CRUISE, DECEL: begin
        if (stop_i && state_q != DECEL) stop_pend_d = 1'b1;
        if (!iv_end) begin
          cnt_d = cnt_q + PER_W'(1);
        end else begin
          // Last clock of the interval: count the step and choose the next
          // interval's period; the next interval starts without a gap.
          cnt_d       = '0;
          done_d      = done_inc;
          target_d    = tgt_eff;
          stop_pend_d = 1'b0;
          if (rem == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (state_q != DECEL && rem <= ramp_q) begin
            state_d  = DECEL;
            period_d = per_up[PER_W-1:0];
            ramp_d   = ramp_dec;
          end else if (state_q == ACCEL) begin
            period_d = per_dn[PER_W-1:0];
            ramp_d   = ramp_q + CNT_W'(1);
            if (per_dn == MIN_X) state_d = CRUISE;
          end else if (state_q == DECEL) begin
            period_d = per_up[PER_W-1:0];
            ramp_d   = ramp_dec;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // step_o is registered from the next-state view so it rises together
    // with the first clock of each interval.
    step_d = (state_d == ACCEL || state_d == CRUISE || state_d == DECEL) && (cnt_d < PW_P);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      period_q    <= START_X[PER_W-1:0];
      cnt_q       <= '0;
      ramp_q      <= '0;
      target_q    <= '0;
      done_q      <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      ramp_q      <= ramp_d;
      target_q    <= target_d;
      done_q      <= done_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = ~busy_q;
  assign dir_o        = dir_q;
  assign step_o       = step_q;
  assign steps_done_o = done_q;

`ifdef STEP_PROFILE_POSITION_EN
  logic signed [CNT_W-1:0] pos_q;

  // Position moves on the same edge that raises step_o; dir_d is already the
  // direction of the move even when there is no setup delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else if (step_d && !step_q) begin
      pos_q <= dir_d ? pos_q - CNT_W'(1) : pos_q + CNT_W'(1);
    end
  end

  assign pos_o = pos_q;
`endif

endmodule

// File: tb/tb_step_profile_gen.sv
// -----------------------------------------------------------------------------
// tb_step_profile_gen
//   Self-checking bench for step_profile_gen with small periods. A
//   step-indexed profile model predicts busy/done/dir/step/steps_done (and
//   pos when STEP_PROFILE_POSITION_EN is defined) for every cycle; a compare
//   process checks the DUT against it each cycle, and directed checks pin
//   the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_step_profile_gen;

  localparam int SP   = 20;
  localparam int MP   = 10;
  localparam int AD   = 5;
  localparam int PW   = 2;
  localparam int DS   = 3;
  localparam int MAXC = 2048;

  logic              clk     = 1'b0;
  logic              rst_ni  = 1'b0;
  logic              start_i = 1'b0;
  logic              stop_i  = 1'b0;
  logic signed [31:0] steps_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              dir_o;
  logic              step_o;
  logic        [31:0] steps_done_o;
`ifdef STEP_PROFILE_POSITION_EN
  logic signed [31:0] pos_o;
`endif

  step_profile_gen #(
    .CNT_W(32), .PER_W(24), .START_PERIOD(SP), .MIN_PERIOD(MP),
    .ACCEL_DEC(AD), .PULSE_W(PW), .DIR_SETUP(DS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .steps_i     (steps_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dir_o       (dir_o),
    .step_o      (step_o),
    .steps_done_o(steps_done_o)
`ifdef STEP_PROFILE_POSITION_EN
    ,
    .pos_o       (pos_o)
`endif
  );

  always #5 clk = ~clk;

  // cycle k = the time between the k-th and (k+1)-th rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // expected outputs per cycle
  logic   exp_busy[MAXC];
  logic   exp_step[MAXC];
  logic   exp_dir [MAXC];
  longint exp_sd  [MAXC];
  longint exp_pos [MAXC];
  int     m_iv[$];

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic put(input int c, input logic b, input logic s, input logic d,
                     input longint sd, input longint p);
    if (c < MAXC) begin
      exp_busy[c] = b; exp_step[c] = s; exp_dir[c] = d;
      exp_sd[c]   = sd; exp_pos[c] = p;
    end
  endtask

  task automatic fill_idle(input int from, input longint sd, input logic d, input longint p);
    for (int c = from; c < MAXC; c++) put(c, 1'b0, 1'b0, d, sd, p);
  endtask

  // Profile model: walks the move one step at a time, applying the ramp
  // rules to a period/ramp pair and a phase (0 up, 1 cruise, 2 down).
  task automatic model_move(input int n, input int s, input int stop_c, output int e);
    longint tgt, done, ramp, per, pos;
    int t, ph;
    logic d;
    d   = exp_dir[n];
    pos = exp_pos[n];
    m_iv.delete();
    tgt = (s < 0) ? -longint'(s) : longint'(s);
    if (tgt == 0) begin
      fill_idle(n + 1, 0, d, pos);
      e = n + 1;
      return;
    end
    d = (s < 0);
    if (stop_c >= n + 1 && stop_c <= n + DS) begin
      for (int c = n + 1; c <= stop_c; c++) put(c, 1'b1, 1'b0, d, 0, pos);
      fill_idle(stop_c + 1, 0, d, pos);
      e = stop_c + 1;
      return;
    end
    for (int c = n + 1; c <= n + DS; c++) put(c, 1'b1, 1'b0, d, 0, pos);
    t = n + 1 + DS; done = 0; ramp = 0; per = SP; ph = 0;
    while (done < tgt) begin
      pos = d ? pos - 1 : pos + 1;
      for (int c = t; c < t + int'(per); c++) put(c, 1'b1, (c - t) < PW, d, done, pos);
      m_iv.push_back(int'(per));
      if (ph != 2 && stop_c >= t && stop_c < t + int'(per) && done + 1 + ramp < tgt)
        tgt = done + 1 + ramp;
      done++;
      t += int'(per);
      if (done < tgt) begin
        if (ph != 2 && tgt - done <= ramp) begin
          ph = 2; per = (per + AD > SP) ? SP : per + AD; ramp = (ramp > 0) ? ramp - 1 : 0;
        end else if (ph == 0) begin
          per = (per - AD < MP) ? MP : per - AD; ramp++;
          if (per == MP) ph = 1;
        end else if (ph == 2) begin
          per = (per + AD > SP) ? SP : per + AD; ramp = (ramp > 0) ? ramp - 1 : 0;
        end
      end
    end
    fill_idle(t, done, d, pos);
    e = t;
  endtask

  task automatic check_iv(input string nm, input int n, input int e[10]);
    check({nm, "_len"}, m_iv.size(), n);
    for (int i = 0; i < n && i < m_iv.size(); i++) check(nm, m_iv[i], e[i]);
  endtask

  // move to just after the rising edge that begins cycle k
  task automatic go_cycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // move to the falling edge inside cycle k
  task automatic at(input int k);
    go_cycle(k);
    @(negedge clk);
  endtask

  task automatic start_move(input int n, input int s, input int stop_c, output int e);
    go_cycle(n);
    start_i = 1'b1;
    steps_i = s;
    model_move(n, s, stop_c, e);
    go_cycle(n + 1);
    start_i = 1'b0;
    steps_i = '0;
    if (stop_c > 0) begin
      go_cycle(stop_c);
      stop_i = 1'b1;
      go_cycle(stop_c + 1);
      stop_i = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("busy",       busy_o,       exp_busy[cyc]);
      check("done",       done_o,       !exp_busy[cyc]);
      check("dir",        dir_o,        exp_dir[cyc]);
      check("step",       step_o,       exp_step[cyc]);
      check("steps_done", steps_done_o, exp_sd[cyc]);
`ifdef STEP_PROFILE_POSITION_EN
      check("pos",        pos_o,        exp_pos[cyc]);
`endif
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: run exceeded %0d cycles", MAXC);
    $fatal(1);
  end

  initial begin
    int n, e;
    fill_idle(0, 0, 1'b0, 0);
    chk_en = 1'b1;
    go_cycle(2);
    rst_ni = 1'b1;

    // reset state
    at(3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 1);
    check("rst_step", step_o, 0);
    check("rst_sd",   steps_done_o, 0);

    // -4 steps
    n = 6;
    start_move(n, -4, -1, e);
    check_iv("iv_m4", 4, '{20, 15, 10, 15, 0, 0, 0, 0, 0, 0});
    check("m4_end", e, n + 64);
    at(n + 3);
    check("m4_dir_setup", dir_o, 1);
    check("m4_step_pre", step_o, 0);
    at(n + 64);
    check("m4_done", done_o, 1);
    check("m4_sd", steps_done_o, 4);
`ifdef STEP_PROFILE_POSITION_EN
    check("m4_pos", pos_o, -4);
`endif

    // 10 steps: full trapezoid
    n = e + 3;
    start_move(n, 10, -1, e);
    check_iv("iv_10", 10, '{20, 15, 10, 10, 10, 10, 10, 10, 15, 20});
    check("m10_end", e, n + 134);
    at(n + 3);
    check("m10_step_pre", step_o, 0);
    check("m10_dir", dir_o, 0);
    at(n + 4);
    check("m10_first_rise", step_o, 1);
    at(n + 133);
    check("m10_done_pre", done_o, 0);
    at(n + 134);
    check("m10_done", done_o, 1);
    check("m10_sd", steps_done_o, 10);

    // zero steps: stays idle, steps_done cleared
    n = e + 3;
    start_move(n, 0, -1, e);
    at(n + 1);
    check("z_busy", busy_o, 0);
    check("z_sd", steps_done_o, 0);

    // stop during direction setup
    n = e + 5;
    start_move(n, 5, n + 2, e);
    check("ss_end", e, n + 3);
    at(n + 3);
    check("ss_done", done_o, 1);
    check("ss_sd", steps_done_o, 0);

    // 100 steps, stop during the 5th interval (cruise, ramp 2)
    n = e + 3;
    start_move(n, 100, n + 62, e);
    check_iv("iv_stop", 7, '{20, 15, 10, 10, 10, 15, 20, 0, 0, 0});
    check("st_end", e, n + 104);
    at(n + 103);
    check("st_done_pre", done_o, 0);
    at(n + 104);
    check("st_sd", steps_done_o, 7);

    // 3 steps: short triangle
    n = e + 3;
    start_move(n, 3, -1, e);
    check_iv("iv_3", 3, '{20, 15, 20, 0, 0, 0, 0, 0, 0, 0});
    at(n + 58);
    check("m3_done_pre", done_o, 0);
    at(n + 59);
    check("m3_done", done_o, 1);
    check("m3_sd", steps_done_o, 3);

    // reset while step_o is high in interval 3
    n = e + 3;
    start_move(n, 10, -1, e);
    go_cycle(n + 39);
    check("pre_rst_step", step_o, 1);
    #2;
    rst_ni = 1'b0;
    fill_idle(n + 39, 0, 1'b0, 0);
    #1;
    check("arst_step", step_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 1);
    check("arst_sd",   steps_done_o, 0);
    go_cycle(n + 42);
    rst_ni = 1'b1;

    // full profile again after reset
    n = n + 45;
    start_move(n, 10, -1, e);
    check_iv("iv_post", 10, '{20, 15, 10, 10, 10, 10, 10, 10, 15, 20});
    at(n + 4);
    check("post_first_rise", step_o, 1);
    at(n + 134);
    check("post_done", done_o, 1);
    check("post_sd", steps_done_o, 10);

    go_cycle(e + 3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
